// File: rtl/spi_apb_sequencer_pkg.sv
// Shared definitions for the SPI APB sequencer: controller register map,
// STATUS bit positions and the sequencing state encoding.
package spi_seq_pkg;

  // SPI controller register offsets (7-bit APB address space)
  localparam logic [6:0] ADDR_CTRL1  = 7'h00;
  localparam logic [6:0] ADDR_INTCLR = 7'h04;
  localparam logic [6:0] ADDR_RXDATA = 7'h08;
  localparam logic [6:0] ADDR_TXDATA = 7'h0C;
  localparam logic [6:0] ADDR_STATUS = 7'h24;
  localparam logic [6:0] ADDR_SSEL   = 7'h28;
  localparam logic [6:0] ADDR_TXLAST = 7'h2C;

  // STATUS.done: the controller has finished shifting the queued frames
  localparam int STATUS_DONE_BIT = 1;

  // Each transfer-issuing state names the APB transfer currently in flight
  typedef enum logic [3:0] {
    ST_INIT_CTRL,
    ST_INIT_SSEL,
    ST_IDLE,
    ST_SSEL_ON,
    ST_INT_CLR,
    ST_TX_WR,
    ST_POLL,
    ST_RX_RD,
    ST_SSEL_OFF,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/spi_apb_sequencer_if.sv
// APB bus bundle between the sequencer (master) and the SPI controller (slave).
interface spi_apb_sequencer_if;
  logic [6:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/spi_apb_sequencer_apb.sv
// Single-transfer APB master: SETUP then ACCESS held until PREADY.
// A start presented in the same cycle as done launches the next SETUP
// back-to-back; request fields are registered so they stay stable.
module apb_master_if (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       write,
  input  logic [7:0] wdata,
  output logic       done,
  output logic       idle,
  output logic [7:0] rdata,
  output logic       err,
  spi_apb_sequencer_if.master apb
);
  logic       psel_q, psel_d;
  logic       penable_q, penable_d;
  logic [6:0] paddr_q, paddr_d;
  logic       pwrite_q, pwrite_d;
  logic [7:0] pwdata_q, pwdata_d;

  assign done  = psel_q & penable_q & apb.PREADY;
  assign idle  = ~psel_q;
  assign rdata = apb.PRDATA;
  assign err   = done & apb.PSLVERR;

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;

  // Phase sequencing: start -> SETUP, SETUP -> ACCESS, ACCESS+PREADY -> idle
  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    if (start) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      paddr_d   = addr;
      pwrite_d  = write;
      pwdata_d  = wdata;
    end else if (psel_q && !penable_q) begin
      penable_d = 1'b1;
    end else if (done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  // Bus registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
    end
  end
endmodule

// File: rtl/spi_apb_sequencer.sv
// Command-level SPI sequencer: turns one (ssel, word) request into the APB
// register sequence select / clear / load TX / poll / drain RX / deselect.
module spi_apb_sequencer
  import spi_seq_pkg::*;
#(
  parameter int         FRAME_SIZE = 4,
  parameter int         N_FRAMES   = 4,
  parameter logic [7:0] CTRL1_INIT = 8'h03,
  parameter int         TIMEOUT    = 1023,
  localparam int        W          = FRAME_SIZE * N_FRAMES
) (
  input  logic         PCLK,
  input  logic         PRESETN,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [7:0]   cmd_ssel,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  spi_apb_sequencer_if.master apb
);
  localparam int FCW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int PCW = $clog2(TIMEOUT + 1);
  localparam logic [FCW-1:0] LAST_FRAME = FCW'(N_FRAMES - 1);
  localparam logic [PCW-1:0] POLL_LIMIT = PCW'(TIMEOUT);

  seq_state_e     state_q, state_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [7:0]     ssel_q, ssel_d;
  logic [W-1:0]   tx_q, tx_d;
  logic [W-1:0]   rx_q, rx_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           err_q, err_d;

  logic       xfer_start, xfer_done, xfer_idle, xfer_err, xfer_write;
  logic [6:0] xfer_addr;
  logic [7:0] xfer_wdata, xfer_rdata;
  logic       in_cmd;

  // Command phase: PSLVERR here is reported; during init it is ignored
  assign in_cmd = state_q inside {ST_SSEL_ON, ST_INT_CLR, ST_TX_WR, ST_POLL,
                                  ST_RX_RD, ST_SSEL_OFF};

  apb_master_if u_apb (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .start (xfer_start),
    .addr  (xfer_addr),
    .write (xfer_write),
    .wdata (xfer_wdata),
    .done  (xfer_done),
    .idle  (xfer_idle),
    .rdata (xfer_rdata),
    .err   (xfer_err),
    .apb   (apb)
  );

  // State register and datapath registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= ST_INIT_CTRL;
      frame_q    <= '0;
      poll_q     <= '0;
      ssel_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      poll_q     <= poll_d;
      ssel_q     <= ssel_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  // Next state: advance when the in-flight transfer completes
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    poll_d     = poll_q;
    ssel_d     = ssel_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    case (state_q)
      ST_INIT_CTRL: if (xfer_done) state_d = ST_INIT_SSEL;
      ST_INIT_SSEL: if (xfer_done) state_d = ST_IDLE;
      ST_IDLE: if (cmd_valid) begin
        state_d = ST_SSEL_ON;
        ssel_d  = cmd_ssel;
        tx_d    = cmd_data;
        rx_d    = '0;
        err_d   = 1'b0;
        poll_d  = '0;
        frame_d = '0;
      end
      ST_SSEL_ON: if (xfer_done) state_d = ST_INT_CLR;
      ST_INT_CLR: if (xfer_done) state_d = ST_TX_WR;
      ST_TX_WR: if (xfer_done) begin
        // The next frame to send is always the MS frame of tx
        tx_d = tx_q << FRAME_SIZE;
        if (frame_q == LAST_FRAME) begin
          frame_d = '0;
          state_d = ST_POLL;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end
      ST_POLL: if (xfer_done) begin
        if (xfer_rdata[STATUS_DONE_BIT]) begin
          state_d = ST_RX_RD;
        end else begin
          poll_d = poll_q + 1'b1;
          if (poll_d == POLL_LIMIT) begin
            err_d   = 1'b1;
            rx_d    = '0;
            state_d = ST_SSEL_OFF;
          end
        end
      end
      ST_RX_RD: if (xfer_done) begin
        rx_d = {rx_q[W-FRAME_SIZE-1:0], xfer_rdata[FRAME_SIZE-1:0]};
        if (frame_q == LAST_FRAME) begin
          frame_d = '0;
          state_d = ST_SSEL_OFF;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end
      ST_SSEL_OFF: if (xfer_done) begin
        rsp_data_d = rx_q;
        state_d    = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_INIT_CTRL;
    endcase
    if (in_cmd && xfer_err) err_d = 1'b1;
  end

  // Outputs: launch the transfer of the state being entered, plus status flags
  always_comb begin
    xfer_addr  = ADDR_CTRL1;
    xfer_write = 1'b1;
    xfer_wdata = 8'h00;
    case (state_d)
      ST_INIT_CTRL: xfer_wdata = CTRL1_INIT;
      ST_INIT_SSEL: xfer_addr  = ADDR_SSEL;
      ST_SSEL_ON: begin
        xfer_addr  = ADDR_SSEL;
        xfer_wdata = ssel_d;
      end
      ST_INT_CLR: begin
        xfer_addr  = ADDR_INTCLR;
        xfer_wdata = 8'hFF;
      end
      ST_TX_WR: begin
        xfer_addr  = (frame_d == LAST_FRAME) ? ADDR_TXLAST : ADDR_TXDATA;
        xfer_wdata = 8'(tx_d[W-1 -: FRAME_SIZE]);
      end
      ST_POLL: begin
        xfer_addr  = ADDR_STATUS;
        xfer_write = 1'b0;
      end
      ST_RX_RD: begin
        xfer_addr  = ADDR_RXDATA;
        xfer_write = 1'b0;
      end
      ST_SSEL_OFF: xfer_addr = ADDR_SSEL;
      default: ;
    endcase
    xfer_start = !(state_d inside {ST_IDLE, ST_RESP}) && (xfer_idle || xfer_done);
    cmd_ready  = (state_q == ST_IDLE);
    busy       = in_cmd;
    rsp_valid  = (state_q == ST_RESP);
    rsp_err    = (state_q == ST_RESP) && err_q;
    rsp_data   = rsp_data_q;
  end
endmodule

// File: tb/tb_spi_apb_sequencer.sv
`timescale 1ns/1ps
module tb_spi_apb_sequencer;
  import spi_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_err, busy;
  logic [7:0]  cmd_ssel;
  logic [15:0] cmd_data, rsp_data;

  always #5 clk = ~clk;

  spi_apb_sequencer_if apb ();

  spi_apb_sequencer #(
    .FRAME_SIZE(4), .N_FRAMES(4), .CTRL1_INIT(8'h03), .TIMEOUT(4)
  ) dut (
    .PCLK(clk), .PRESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ssel(cmd_ssel), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .apb(apb)
  );

  int total = 0;
  int bad = 0;

  // APB completer model and transfer log
  int          wait_states = 0;
  int          wait_cnt = 0;
  logic [7:0]  status_val = 8'h02;
  logic [7:0]  rx_frames [4];
  int          rx_total = 0;
  int          rx_base = 0;
  int          log_n = 0;
  int          err_at = -1;
  int          rsp_cnt = 0;
  int          cmd_base = 0;
  logic [15:0] log_rec [256];
  logic [1:0]  rx_idx;

  assign rx_idx      = 2'(rx_total - rx_base);
  assign apb.PREADY  = (wait_cnt >= wait_states);
  assign apb.PRDATA  = (apb.PADDR == ADDR_STATUS) ? status_val :
                       (apb.PADDR == ADDR_RXDATA) ? rx_frames[rx_idx] : 8'h00;
  assign apb.PSLVERR = apb.PSEL && apb.PENABLE && (log_n == err_at);

  always @(posedge clk) begin
    if (apb.PSEL && apb.PENABLE) wait_cnt <= apb.PREADY ? 0 : wait_cnt + 1;
    else wait_cnt <= 0;
    if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
      log_rec[log_n[7:0]] <= {apb.PADDR, apb.PWRITE, apb.PWRITE ? apb.PWDATA : 8'h00};
      log_n <= log_n + 1;
      if (!apb.PWRITE && apb.PADDR == ADDR_RXDATA) rx_total <= rx_total + 1;
      $display("apb %0d: addr=%02h %s data=%02h slverr=%0b", log_n, apb.PADDR,
               apb.PWRITE ? "W" : "R", apb.PWRITE ? apb.PWDATA : apb.PRDATA, apb.PSLVERR);
    end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk(tag, {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA,
              cmd_ready, rsp_valid, rsp_err, busy, rsp_data}, 32'h0);
  endtask

  // Expected APB sequence of one command; frames packed f0 in [31:24]
  task automatic chk_seq(input string tag, input logic [7:0] ssel, input logic [31:0] frames,
                         input int polls, input bit rx);
    logic [15:0] e[$];
    logic [7:0]  f;
    e.push_back({ADDR_SSEL, 1'b1, ssel});
    e.push_back({ADDR_INTCLR, 1'b1, 8'hFF});
    for (int k = 0; k < 4; k++) begin
      f = frames[31-8*k -: 8];
      e.push_back({(k == 3) ? ADDR_TXLAST : ADDR_TXDATA, 1'b1, f});
    end
    for (int p = 0; p < polls; p++) e.push_back({ADDR_STATUS, 1'b0, 8'h00});
    if (rx) for (int k = 0; k < 4; k++) e.push_back({ADDR_RXDATA, 1'b0, 8'h00});
    e.push_back({ADDR_SSEL, 1'b1, 8'h00});
    chk({tag, "_xfer_count"}, log_n - cmd_base, e.size());
    foreach (e[i]) chk({tag, "_xfer"}, log_rec[8'(cmd_base + i)], e[i]);
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] ssel, input logic [15:0] data,
                         input logic [15:0] exp_data, input logic exp_err, input int exp_cyc);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, cmd_ready, 1);
    cmd_base  = log_n;
    rx_base   = rx_total;
    cmd_valid = 1'b1;
    cmd_ssel  = ssel;
    cmd_data  = data;
    @(negedge clk);
    // Keep a bogus request asserted while busy: it must be ignored
    cmd_ssel = 8'hEE;
    cmd_data = 16'hFFFF;
    n = 1;
    chk({tag, "_accept"}, {busy, cmd_ready, apb.PSEL, apb.PENABLE}, 4'b1010);
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 5) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    $display("cmd %s ssel=%02h data=%04h -> rsp=%04h err=%0b cycle=%0d", tag, ssel, data,
             rsp_data, rsp_err, n);
    chk({tag, "_rsp_cycle"}, n, exp_cyc);
    chk({tag, "_rsp_data"}, rsp_data, exp_data);
    chk({tag, "_rsp_err"}, rsp_err, exp_err);
    @(negedge clk);
    chk({tag, "_after_rsp"}, {rsp_valid, rsp_err, busy, cmd_ready, rsp_data},
        {1'b0, 1'b0, 1'b0, 1'b1, exp_data});
  endtask

  initial begin
    int n;
    int rsp_before;
    cmd_valid = 1'b0;
    cmd_ssel  = 8'h00;
    cmd_data  = 16'h0000;
    rx_frames = '{8'hE5, 8'h7A, 8'h03, 8'h9C};

    // Reset and init sequence
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("reset_async");
    @(negedge clk);
    @(negedge clk);
    chk_zero_outputs("reset_held");
    cmd_base = log_n;
    rst_n = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("init_ready_cycle", n, 5);
    chk("init_xfer_count", log_n - cmd_base, 2);
    chk("init_ctrl1", log_rec[8'(cmd_base)], {ADDR_CTRL1, 1'b1, 8'h03});
    chk("init_ssel", log_rec[8'(cmd_base + 1)], {ADDR_SSEL, 1'b1, 8'h00});

    // Basic command, zero wait states, done on first poll
    run_cmd("basic", 8'h01, 16'hA5C3, 16'h5A3C, 1'b0, 25);
    chk_seq("basic", 8'h01, 32'h0A050C03, 1, 1'b1);

    // PSLVERR on the second TXDATA write: sequence completes, error reported
    err_at = log_n + 3;
    run_cmd("slverr", 8'h02, 16'h1234, 16'h5A3C, 1'b1, 25);
    chk_seq("slverr", 8'h02, 32'h01020304, 1, 1'b1);
    err_at = -1;

    // Two wait states on every transfer; error flag must not carry over
    wait_states = 2;
    run_cmd("wait2", 8'h01, 16'hA5C3, 16'h5A3C, 1'b0, 49);
    chk_seq("wait2", 8'h01, 32'h0A050C03, 1, 1'b1);
    wait_states = 0;

    // STATUS never done (other bits set): timeout after 4 polls
    status_val = 8'hFD;
    run_cmd("timeout", 8'h04, 16'h0F0F, 16'h0000, 1'b1, 23);
    chk_seq("timeout", 8'h04, 32'h000F000F, 4, 1'b0);
    status_val = 8'h02;

    // Reset during RX_RD: immediate clear, init re-runs, no response
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    rx_base    = rx_total;
    rsp_before = rsp_cnt;
    cmd_valid  = 1'b1;
    cmd_ssel   = 8'h08;
    cmd_data   = 16'h7777;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(apb.PSEL && apb.PADDR == ADDR_RXDATA) && n < 100) begin @(negedge clk); n++; end
    chk("midreset_reached_rx", apb.PADDR, ADDR_RXDATA);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("midreset_async");
    @(negedge clk);
    cmd_base = log_n;
    rst_n = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("midreset_ready_cycle", n, 5);
    chk("midreset_init_ctrl1", log_rec[8'(cmd_base)], {ADDR_CTRL1, 1'b1, 8'h03});
    chk("midreset_init_ssel", log_rec[8'(cmd_base + 1)], {ADDR_SSEL, 1'b1, 8'h00});
    chk("midreset_no_rsp", rsp_cnt - rsp_before, 0);
    chk("midreset_rsp_data", rsp_data, 16'h0000);

    // Normal operation resumes after the abandoned command
    run_cmd("resume", 8'h01, 16'hA5C3, 16'h5A3C, 1'b0, 25);
    chk_seq("resume", 8'h01, 32'h0A050C03, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_apb_sequencer.md
# spi_apb_sequencer

APB master that sits directly upstream of the SPI controller core (8-bit APB, 7-bit address, 4-bit frames) and turns one command-level request into an APB register sequence. Each request carries a slave select and a data word; the sequencer selects the slave, loads the TX FIFO, polls until the transfer is done, then drains the RX FIFO. It returns the received word to the digitizer's configuration logic, which uses it for ADC/PLL register access.

## Interface
- FRAME_SIZE, 4, bits per SPI frame
- N_FRAMES, 4, frames per command; word width W = FRAME_SIZE*N_FRAMES = 16
- CTRL1_INIT, 8'h03, CTRL1 value written at init (enable, master)
- TIMEOUT, 1023, maximum STATUS polls before abort

Ports:
- PCLK  in  1  clock
- PRESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer idle, command accepted on valid&ready
- cmd_ssel  in  8  SSEL register value for this command
- cmd_data  in  W  TX word, MS frame sent first
- rsp_valid  out  1  one-cycle pulse, response available
- rsp_data  out  W  RX word, first received frame in MS bits
- rsp_err  out  1  valid with rsp_valid, PSLVERR seen or timeout
- busy  out  1  high from acceptance until rsp_valid
- PADDR  out  7, PSEL out 1, PENABLE out 1, PWRITE out 1, PWDATA out 8  APB master request
- PRDATA  in  8, PREADY in 1, PSLVERR in 1  APB completer response

## Operation
- States: INIT_CTRL, INIT_SSEL, IDLE, SSEL_ON, INT_CLR, TX_WR, POLL, RX_RD, SSEL_OFF, RESP.
- INIT_CTRL: write CTRL1=CTRL1_INIT. INIT_SSEL: write SSEL=0. Then IDLE. Init errors are ignored.
- IDLE: cmd_ready=1. On acceptance, latch cmd_ssel and cmd_data, clear the error and timeout counters, go to SSEL_ON.
- SSEL_ON: write SSEL=cmd_ssel. INT_CLR: write INTCLR=8'hFF.
- TX_WR: frames k=0..N_FRAMES-2 are written to TXDATA. Frame N_FRAMES-1 is written to TXLAST. Frame k = cmd_data[W-1-k*FRAME_SIZE -: FRAME_SIZE], zero-extended to 8 bits.
- POLL: read STATUS. If bit 1 (done) is set, go to RX_RD. Otherwise increment the poll count and re-read.
  - When the poll count reaches TIMEOUT, set err, force rsp_data=0, and go to SSEL_OFF.
- RX_RD: N_FRAMES reads of RXDATA. Shift PRDATA[FRAME_SIZE-1:0] into rsp_data from the LSB.
- SSEL_OFF: write SSEL=0. It is always executed, including after an error.
- RESP: rsp_valid=1 for one cycle, rsp_err=err, then IDLE.
- PSLVERR=1 on any completed command-phase transfer sets a sticky err. The sequence continues unchanged.

## Timing
- APB transfer: SETUP cycle (PSEL=1, PENABLE=0), then ACCESS (PENABLE=1) held until PREADY=1. PADDR, PWRITE and PWDATA are stable across both.
- The next SETUP follows the completing ACCESS cycle with no idle cycle. PSEL stays low in IDLE and RESP.
- Acceptance at cycle 0, first SETUP at cycle 1.
- With zero wait states, done on the first poll and N_FRAMES=4: 12 transfers occupy cycles 1–24, rsp_valid at cycle 25.
- Each extra poll adds 2 cycles. Each wait state adds 1 cycle.
- Reset values: PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, rsp_err, busy = 0; PADDR, PWDATA, rsp_data = 0. State resets to INIT_CTRL.
- Reset mid-command: everything is abandoned immediately and init re-runs. No response is emitted for the lost command.
- cmd_valid while busy is ignored (cmd_ready=0). rsp_data holds until the next RESP.

## Structure
- Package spi_seq_pkg holds:
  - register offsets: CTRL1=7'h00, INTCLR=7'h04, RXDATA=7'h08, TXDATA=7'h0C, STATUS=7'h24, SSEL=7'h28, TXLAST=7'h2C
  - STATUS_DONE_BIT=1
  - the state enum
- Sub-module apb_master_if: the SETUP/ACCESS handshake. Inputs are start, addr, write, wdata; outputs are done, rdata, err. The top level holds the sequencing FSM, frame counter, poll counter and data shift registers.

## Test plan
- Reset release, PREADY=1 -> writes CTRL1=8'h03 then SSEL=8'h00. cmd_ready rises the cycle after the second ACCESS.
- cmd_ssel=8'h01, cmd_data=16'hA5C3; STATUS reads 8'h02 on first poll; RXDATA returns 5,A,3,C -> TX frames A,5,C (TXDATA) and 3 (TXLAST). rsp_data=16'h5A3C, rsp_err=0, rsp_valid at cycle 25.
- Same command with PREADY low 2 cycles on every transfer -> identical APB sequence, rsp_valid at cycle 49.
- STATUS never reports done, TIMEOUT=4 -> 4 STATUS reads, then SSEL=0 write. rsp_data=0, rsp_err=1.
- PSLVERR=1 on the second TXDATA write -> full sequence still completes including SSEL=0, rsp_err=1.
- PRESETN pulsed low during RX_RD -> all outputs 0 asynchronously, init re-runs, no rsp_valid.
